alu_share_arbiter: RTL

Two-requester arbiter and sequencer that shares the single 32-bit ALU between two pipeline clients: port 0 is the EX stage and port 1 is the early branch-compare unit. It accepts operations over valid/ready handshakes and grants them round-robin. It drives the ALU's operand and control inputs from registers, captures the combinational result one cycle later, and returns the result, with owner and tag, through a one-entry response buffer. Codes the ALU does not support are rejected locally and never reach the ALU.

---
 rtl/alu_share_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit ALU between the EX stage (port 0)
// and the early branch-compare unit (port 1), with a one-entry response buffer.
module alu_share_arbiter #(
    parameter int unsigned TAGW = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [3:0]      req0_ctrl,
    input  logic [TAGW-1:0] req0_tag,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic [3:0]      req1_ctrl,
    input  logic [TAGW-1:0] req1_tag,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [31:0]     alu_c,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_owner,
    output logic [31:0]     rsp_c,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic [TAGW-1:0] rsp_tag
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last;
    logic                err;
    logic                owner_q;
    logic [TAGW-1:0]     tag_q;

    logic [1:0]          gnt;
    logic                window;
    logic                accept;
    logic                sel;
    logic [DW-1:0]       sel_a;
    logic [DW-1:0]       sel_b;
    logic [CW-1:0]       sel_ctrl;
    logic [TAGW-1:0]     sel_tag;
    logic                sel_err;

    // Codes the ALU implements; anything else is answered locally with rsp_err.
    function automatic logic ctrl_supported(input logic [CW-1:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
            4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010: ctrl_supported = 1'b1;
            default:                                              ctrl_supported = 1'b0;
        endcase
    endfunction

    // Grant, accept window and next state.
    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        window = (state == IDLE) || ((state == RESP) && rsp_ready);
        if (window) begin
            req_ready = gnt;
        end
        accept = |req_ready;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Selected requester's payload.
    always_comb begin
        sel      = req_ready[1];
        sel_a    = sel ? req1_a    : req0_a;
        sel_b    = sel ? req1_b    : req0_b;
        sel_ctrl = sel ? req1_ctrl : req0_ctrl;
        sel_tag  = sel ? req1_tag  : req0_tag;
        sel_err  = !ctrl_supported(sel_ctrl);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand issue, result capture and response buffer.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last      <= 1'b1;
            err       <= 1'b0;
            owner_q   <= 1'b0;
            tag_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_c     <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            if (accept) begin
                last     <= sel;
                owner_q  <= sel;
                tag_q    <= sel_tag;
                err      <= sel_err;
                alu_a    <= sel_err ? DW'(0) : sel_a;
                alu_b    <= sel_err ? DW'(0) : sel_b;
                alu_ctrl <= sel_err ? CW'(0) : sel_ctrl;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_owner <= owner_q;
                rsp_tag   <= tag_q;
                rsp_err   <= err;
                rsp_c     <= err ? DW'(0) : alu_c;
                rsp_zero  <= err ? 1'b0 : alu_zero;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
